// File: rtl/life_disp_pkg.sv
// Shared types and width helpers for the Game-of-Life LED-matrix scan path.
package life_disp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_BLANK
  } scan_state_t;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  // Index width for an n-entry dimension; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int dwell, input int blank);
    return $clog2(((dwell > blank) ? dwell : blank) + 1);
  endfunction

endpackage

// File: rtl/life_matrix_scan_if.sv
// Host/display bundle for the matrix scanner: cell writes, swap handshake, row/column drive.
interface life_matrix_scan_if
  import life_disp_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);
  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);

  logic             disp_en;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic             wr_bit;
  logic             swap_req;
  logic             swap_ack;
  logic             swap_pending;
  logic [ROWS-1:0]  row_sel;
  logic [COLS-1:0]  col_on;
  logic             frame_start;

  modport master (
    output disp_en, wr_en, wr_row, wr_col, wr_bit, swap_req,
    input  swap_ack, swap_pending, row_sel, col_on, frame_start
  );

  modport slave (
    input  disp_en, wr_en, wr_row, wr_col, wr_bit, swap_req,
    output swap_ack, swap_pending, row_sel, col_on, frame_start
  );

endinterface

// File: rtl/frame_buffer.sv
// Two ROWS x COLS bit banks: writes go to the back bank, reads come from the front bank.
module frame_buffer
  import life_disp_pkg::*;
#(
  parameter  int ROWS  = DEF_ROWS,
  parameter  int COLS  = DEF_COLS,
  localparam int ROW_W = idx_w(ROWS),
  localparam int COL_W = idx_w(COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic             wr_bit,
  input  logic             swap,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data
);

  logic [COLS-1:0] bank [2][ROWS];
  logic            front_sel;
  logic            wr_ok;

  assign wr_ok = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

  // NOTE: storage arrays carry no reset; resetting them would turn RAM into a flop bank.
  always_ff @(posedge clk) begin
    if (wr_ok) bank[~front_sel][wr_row][wr_col] <= wr_bit;
  end

  // A write in the swap cycle still uses the old front_sel, so it lands in the bank about to be shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    front_sel <= 1'b0;
    else if (swap) front_sel <= ~front_sel;
  end

  assign rd_data = bank[front_sel][rd_row];

endmodule

// File: rtl/life_matrix_scan.sv
// Row-multiplexed matrix scanner with dwell/blank timing and tear-free bank swap at frame boundaries.
module life_matrix_scan
  import life_disp_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input logic               clk,
  input logic               rst_n,
  life_matrix_scan_if.slave bus
);

  localparam int ROW_W = idx_w(ROWS);
  localparam int CNT_W = cnt_w(DWELL, BLANK);

  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] LAST_ON    = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK - 1);

  scan_state_t      state, state_nx;
  logic [ROW_W-1:0] row, row_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pending, pending_nx, swap_now, ack_d;
  logic [COLS-1:0]  front_row;

  logic             lit;
  logic [ROWS-1:0]  row_one, row_sel_nx, row_sel_q;
  logic [COLS-1:0]  col_on_nx, col_on_q;
  logic             frame_start_nx, frame_start_q;
  logic             swap_pending_nx, swap_pending_q, swap_ack_q;

  frame_buffer #(.ROWS(ROWS), .COLS(COLS)) u_fb (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_row  (bus.wr_row),
    .wr_col  (bus.wr_col),
    .wr_bit  (bus.wr_bit),
    .swap    (swap_now),
    .rd_row  (row),
    .rd_data (front_row)
  );

  assign swap_now   = pending && ((state == S_IDLE) ||
                      (state == S_BLANK && cnt == LAST_BLANK && row == LAST_ROW));
  assign pending_nx = (pending && !swap_now) || bus.swap_req;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      ack_d   <= 1'b0;
    end else begin
      state   <= state_nx;
      row     <= row_nx;
      cnt     <= cnt_nx;
      pending <= pending_nx;
      ack_d   <= swap_now;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    row_nx   = row;
    cnt_nx   = cnt + CNT_W'(1);
    if (!bus.disp_en) begin
      state_nx = S_IDLE;
      row_nx   = '0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_nx = S_ON;
          row_nx   = '0;
          cnt_nx   = '0;
        end
        S_ON: if (cnt == LAST_ON) begin
          state_nx = S_BLANK;
          cnt_nx   = '0;
        end
        S_BLANK: if (cnt == LAST_BLANK) begin
          state_nx = S_ON;
          cnt_nx   = '0;
          row_nx   = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
        end
        default: begin
          state_nx = S_IDLE;
          row_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs trail the state by one register; the ack is delayed to match so it lands on frame_start.
  always_comb begin
    lit          = bus.disp_en && (state == S_ON);
    row_one      = '0;
    row_one[row] = 1'b1;
    row_sel_nx   = lit ? row_one : '0;
    col_on_nx    = '0;
    if (lit) col_on_nx = (cnt == '0) ? front_row : col_on_q;
    frame_start_nx  = lit && (row == '0) && (cnt == '0);
    swap_pending_nx = pending_nx || swap_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sel_q      <= '0;
      col_on_q       <= '0;
      frame_start_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_ack_q     <= 1'b0;
    end else begin
      row_sel_q      <= row_sel_nx;
      col_on_q       <= col_on_nx;
      frame_start_q  <= frame_start_nx;
      swap_pending_q <= swap_pending_nx;
      swap_ack_q     <= ack_d;
    end
  end

  assign bus.row_sel      = row_sel_q;
  assign bus.col_on       = col_on_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.swap_pending = swap_pending_q;
  assign bus.swap_ack     = swap_ack_q;

endmodule

// File: tb/tb_life_matrix_scan.sv
// Directed bench for life_matrix_scan: 4x4 matrix, DWELL=3, BLANK=1, 16-cycle frame.
module tb_life_matrix_scan;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DWELL = 3;
  localparam int BLANK = 1;
  localparam int FRAME = ROWS * (DWELL + BLANK);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   pos   = 0;

  life_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  life_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic wr(input logic [1:0] r, input logic [1:0] c, input logic b);
    bus.wr_row = r;
    bus.wr_col = c;
    bus.wr_bit = b;
    bus.wr_en  = 1'b1;
    step();
    bus.wr_en  = 1'b0;
  endtask

  task automatic pulse_swap();
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_row_sel"}, 32'(bus.row_sel), 32'(0));
    check({tag, "_col_on"}, 32'(bus.col_on), 32'(0));
    check({tag, "_frame_start"}, 32'(bus.frame_start), 32'(0));
  endtask

  task automatic check_swap(input string tag, input logic ack, input logic pend);
    check({tag, "_ack"}, 32'(bus.swap_ack), 32'(ack));
    check({tag, "_pending"}, 32'(bus.swap_pending), 32'(pend));
  endtask

  // Expected display at frame position pos: rows lit for DWELL cycles, then BLANK dark.
  task automatic expect_scan(input logic [15:0] img);
    int r, ph;
    logic [3:0] one, rs, co;
    r   = pos / (DWELL + BLANK);
    ph  = pos % (DWELL + BLANK);
    one = 4'b0001;
    rs  = (ph < DWELL) ? (one << r) : 4'b0000;
    co  = (ph < DWELL) ? img[r*4 +: 4] : 4'b0000;
    check($sformatf("row_sel@%0d", pos), 32'(bus.row_sel), 32'(rs));
    check($sformatf("col_on@%0d", pos), 32'(bus.col_on), 32'(co));
    check($sformatf("frame_start@%0d", pos), 32'(bus.frame_start), 32'(pos == 0));
  endtask

  task automatic scan(input logic [15:0] img, input int n);
    for (int k = 0; k < n; k++) begin
      expect_scan(img);
      step();
    end
  endtask

  task automatic start_scan();
    bus.disp_en = 1'b1;
    step();
    check("pre_frame_row_sel", 32'(bus.row_sel), 32'(0));
    check("pre_frame_start", 32'(bus.frame_start), 32'(0));
    step();
    pos = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bus.disp_en  = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_row   = '0;
    bus.wr_col   = '0;
    bus.wr_bit   = 1'b0;
    bus.swap_req = 1'b0;

    // Reset state
    step();
    step();
    check_dark("reset");
    check_swap("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Clear back bank 1, swap in IDLE with exact ack timing, then clear bank 0
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wr(2'(r), 2'(c), 1'b0);
    pulse_swap();
    check_swap("idle_swap_t1", 1'b0, 1'b1);
    step();
    check_swap("idle_swap_t2", 1'b0, 1'b1);
    step();
    check_swap("idle_swap_t3", 1'b1, 1'b0);
    step();
    check("idle_swap_t4_ack", 32'(bus.swap_ack), 32'(0));
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wr(2'(r), 2'(c), 1'b0);
    pulse_swap();
    step();
    step();
    check("idle_swap2_ack", 32'(bus.swap_ack), 32'(1));
    step();

    // Basic scan: two blank frames
    start_scan();
    scan(16'h0000, 2 * FRAME);

    // Mid-frame write of row 2 = 1010 and swap request; old frame must stay unchanged
    wr(2'd2, 2'd0, 1'b0);
    wr(2'd2, 2'd1, 1'b1);
    wr(2'd2, 2'd2, 1'b0);
    wr(2'd2, 2'd3, 1'b1);
    pulse_swap();
    repeat (11) begin
      expect_scan(16'h0000);
      check_swap("pend_hold", 1'b0, 1'b1);
      step();
    end
    check_swap("boundary_swap", 1'b1, 1'b0);
    scan(16'h0A00, FRAME);

    // Three requests in one frame, plus a write in the swap_now cycle
    check("no_extra_ack", 32'(bus.swap_ack), 32'(0));
    pulse_swap();
    step();
    step();
    pulse_swap();
    step();
    step();
    pulse_swap();
    check("merged_pending", 32'(bus.swap_pending), 32'(1));
    while (pos != 14) step();
    wr(2'd2, 2'd3, 1'b1);
    check_swap("pre_boundary", 1'b0, 1'b1);
    step();
    check_swap("merged_swap", 1'b1, 1'b0);
    for (int k = 0; k < 2 * FRAME; k++) begin
      expect_scan(16'h0800);
      if (k > 0) check("single_ack", 32'(bus.swap_ack), 32'(0));
      step();
    end

    // disp_en low mid-row with a swap pending: dark at once, swap completes in IDLE
    step();
    pulse_swap();
    bus.disp_en = 1'b0;
    step();
    check_dark("disable");
    check_swap("disable_t1", 1'b0, 1'b1);
    step();
    check_swap("disable_t2", 1'b0, 1'b1);
    step();
    check_swap("disable_t3", 1'b1, 1'b0);
    step();
    check("disable_t4_ack", 32'(bus.swap_ack), 32'(0));
    start_scan();
    scan(16'h0A00, FRAME);

    // Asynchronous reset mid-BLANK with a swap pending
    pulse_swap();
    step();
    expect_scan(16'h0A00);
    check("pre_reset_pending", 32'(bus.swap_pending), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    check_swap("async_reset", 1'b0, 1'b0);
    bus.disp_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check_swap("post_reset", 1'b0, 1'b0);
    start_scan();
    check("post_reset_frame_ack", 32'(bus.swap_ack), 32'(0));
    scan(16'h0800, FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
